// File: rtl/round_sat.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// round_sat
//
// Registered round-half-up stage with saturation for a valid/ready stream.
// It sits directly in front of a truncate stage that drops the NBITS LSBs.
// Each word gets half an LSB of the retained precision added, and clamps on
// overflow. The low NBITS bits of the output are already zero, so the
// truncate that follows yields a correctly rounded value and leaves this data
// unchanged.
//
// Buffering is a main register plus a one-entry skid register. This gives
// full throughput with a registered din_ready. dout always reflects the main
// entry.
//
// Parameters
//   NBITS  : number of LSBs dropped downstream (rounding position), 0..DIN-1.
//            With NBITS=0 the block is a plain registered pass-through.
//   DIN    : data width of din_data and dout_data.
//   SIGNED : 1 = two's-complement data, 0 = unsigned data.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous reset, active low; discards all buffered words
//   din_data   : input word
//   din_valid  : input word valid
//   din_ready  : stage can accept (registered, low only while skid is full)
//   dout_data  : rounded, saturated word (low NBITS bits always 0)
//   dout_valid : output word valid
//   dout_ready : downstream accepts
//   sat        : qualified by dout_valid, current dout word was saturated
// ----------------------------------------------------------------------------
module round_sat #(
    parameter int NBITS  = 0,
    parameter int DIN    = 16,
    parameter int SIGNED = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DIN-1:0] din_data,
    input  logic           din_valid,
    output logic           din_ready,
    output logic [DIN-1:0] dout_data,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           sat
);

    // Occupancy of the main/skid pair. FULL means both entries hold a word.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [DIN-1:0] main_data_reg, main_data_next;
    logic           main_sat_reg, main_sat_next;
    logic [DIN-1:0] skid_data_reg, skid_data_next;
    logic           skid_sat_reg, skid_sat_next;
    logic           din_ready_reg, din_ready_next;

    // Combinational rounding result for the word currently on din.
    logic [DIN-1:0] rnd_data;
    logic           rnd_sat;

    logic in_xfer;
    logic out_xfer;

    genvar gi;

    // ------------------------------------------------------------------------
    // Rounding / saturation datapath
    // ------------------------------------------------------------------------
    generate
        if (NBITS > 0) begin : gen_round
            // Half an LSB of the retained precision, at DIN+1 bits so the
            // unsigned carry-out is visible in the top bit.
            localparam logic [DIN:0] HALF_LSB = {{DIN{1'b0}}, 1'b1} << (NBITS - 1);

            logic [DIN-1:0] keep_mask;
            logic [DIN-1:0] sat_value;
            logic [DIN:0]   sum;
            logic           ext_msb;
            logic           ovf;

            // Mask that clears the NBITS LSBs the downstream truncate drops.
            for (gi = 0; gi < DIN; gi++) begin : gen_mask
                assign keep_mask[gi] = (gi >= NBITS);
            end

            assign ext_msb = (SIGNED != 0) ? din_data[DIN-1] : 1'b0;
            assign sum     = {ext_msb, din_data} + HALF_LSB;

            // Signed: only a non-negative input can wrap into the sign bit.
            // Negative inputs move toward zero and never overflow.
            // Unsigned: overflow is the carry out of the DIN-bit sum.
            assign ovf = (SIGNED != 0) ? (!din_data[DIN-1] && sum[DIN-1])
                                       : sum[DIN];

            // Largest representable value, with its dropped LSBs cleared.
            assign sat_value = (SIGNED != 0)
                             ? ({1'b0, {(DIN-1){1'b1}}} & keep_mask)
                             : ({DIN{1'b1}} & keep_mask);

            assign rnd_data = ovf ? sat_value : (sum[DIN-1:0] & keep_mask);
            assign rnd_sat  = ovf;
        end else begin : gen_pass
            assign rnd_data = din_data;
            assign rnd_sat  = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign dout_valid = (state_reg == ST_ONE) || (state_reg == ST_FULL);
    assign in_xfer    = din_valid && din_ready_reg;
    assign out_xfer   = dout_valid && dout_ready;

    assign din_ready  = din_ready_reg;
    assign dout_data  = main_data_reg;
    assign sat        = main_sat_reg;

    // ------------------------------------------------------------------------
    // Next-state logic for the main/skid pair
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        main_sat_next  = main_sat_reg;
        skid_data_next = skid_data_reg;
        skid_sat_next  = skid_sat_reg;

        unique case (state_reg)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_next     = ST_ONE;
                    main_data_next = rnd_data;
                    main_sat_next  = rnd_sat;
                end
            end

            ST_ONE: begin
                case ({in_xfer, out_xfer})
                    2'b11: begin
                        // Main drains and refills in the same edge.
                        main_data_next = rnd_data;
                        main_sat_next  = rnd_sat;
                    end
                    2'b10: begin
                        // Main is stalled: park the new word in the skid entry.
                        state_next     = ST_FULL;
                        skid_data_next = rnd_data;
                        skid_sat_next  = rnd_sat;
                    end
                    2'b01: begin
                        // Main data is left in place; it is don't-care now.
                        state_next = ST_EMPTY;
                    end
                    default: begin
                    end
                endcase
            end

            ST_FULL: begin
                // din_ready is low here, so only the output side can move.
                if (out_xfer) begin
                    state_next     = ST_ONE;
                    main_data_next = skid_data_reg;
                    main_sat_next  = skid_sat_reg;
                end
            end

            default: begin
                state_next = ST_EMPTY;
            end
        endcase

        // Ready is a pure function of the next occupancy, so it can be
        // registered without losing a cycle of throughput.
        din_ready_next = (state_next != ST_FULL);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_EMPTY;
            main_data_reg <= '0;
            main_sat_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_sat_reg  <= 1'b0;
            din_ready_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            main_sat_reg  <= main_sat_next;
            skid_data_reg <= skid_data_next;
            skid_sat_reg  <= skid_sat_next;
            din_ready_reg <= din_ready_next;
        end
    end

endmodule
